execute_stage_pipe: RTL
=======================

# execute_stage_pipe

Parametrised execute stage for the pipelined CPU: a registered decode→execute slot, the ALU with a sticky N/Z/C/V flag register, address/store-data routing, and a registered execute→memory slot, joined by valid/ready handshakes instead of free-running registers. It generalises the fixed 16-bit execute path to any `WIDTH`, adds stall, flush and back-pressure, and optionally adds an iterative multi-cycle multiplier. It sits between the decode stage and the memory stage.

## Interface
- `WIDTH`, 16, datapath width in bits (≥ 8, power of two).
- `SHAMT_W`, $clog2(WIDTH), shift-amount width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  kill the instruction in the execute slot.
- `in_valid`  in  1  the decode stage presents an instruction.
- `in_ready`  out  1  the execute slot accepts an instruction this cycle.
- `wbs_in`, `wme_in`, `mm_in`, `wm_in`, `am_in`, `ni_in`  in  1 each  control bits carried through the stage.
- `ALUop_in`  in  3  ALU operation.
- `srcA_in`, `srcB_in`  in  WIDTH  operands.
- `out_valid`  out  1  the memory slot holds a result.
- `out_ready`  in  1  the memory stage consumes the result.
- `wbs_out`, `wme_out`, `mm_out`, `wm_out`, `ni_out`  out  1 each  registered control bits.
- `ALUresult_out`, `memData_out`  out  WIDTH  result/address and store data.
- `flagN`, `flagZ`, `flagC`, `flagV`  out  1 each  sticky flag register.
- `busy`  out  1  the multiplier is iterating.

## Operation
- ALUop encoding:
  - 000 MOV (B)
  - 001 ADD
  - 010 SUB (A−B)
  - 011 AND
  - 100 OR
  - 101 XOR
  - 110 SHL (A << B[SHAMT_W-1:0])
  - 111 MUL (low WIDTH bits of A·B)
- Results are truncated to WIDTH bits.
  - ADD: C = carry out; V = signed overflow.
  - SUB: C = no-borrow (A ≥ B unsigned).
  - All other ops: C and V are cleared.
- Address/store routing:
  - am=1: `ALUresult_out` = srcA (address) and `memData_out` = srcB. Flags are unchanged.
  - am=0: `ALUresult_out` = ALU result and `memData_out` = 0.
- Flag update: N = result MSB and Z = (result == 0) are written only when an am=0 instruction moves from the execute slot to the memory slot.
- Slot advance: `advance = E_valid && !busy && (!out_valid || out_ready)`.
- Input handshake: `in_ready = !flush && !busy && (!E_valid || advance)`. Capture occurs when `in_valid && in_ready`.
- Multiplier FSM states: IDLE → MUL → DONE → IDLE.
  - IDLE→MUL when a MUL instruction is captured.
  - MUL performs WIDTH shift-add iterations, one bit per cycle.
  - DONE lasts one cycle: `busy` drops and the product is available to `advance`.
- Flush: clears `E_valid` and aborts the multiplier to IDLE. The memory slot is untouched. A flush in the capture cycle drops the incoming instruction.
- Reset values:
  - all slot valids 0
  - all outputs 0
  - flags 0
  - FSM in IDLE
  - `busy` 0
  - `in_ready` 1 after reset release

## Timing
- Single-cycle ops have a latency of 2 edges with no back-pressure: capture at edge 1, `out_valid` at edge 2.
- Full throughput is 1 instruction per cycle.
- MUL latency is WIDTH+3 edges from capture to `out_valid`. `in_ready` is 0 for WIDTH+1 cycles after capture.
- Back-pressure: with `out_valid && !out_ready`, every memory-slot output is held stable and the execute slot holds its contents.
- When the memory slot drains and the execute slot refills in the same cycle, the new value is loaded with no bubble.
- Reset asserted mid-MUL returns to IDLE immediately; the partial product is discarded.

## Configuration
- `EXEC_MUL_EN` defined:
  - The iterative multiplier and FSM are built.
  - ALUop 111 behaves as described in Operation.
- `EXEC_MUL_EN` undefined:
  - No FSM; `busy` is tied to 0.
  - ALUop 111 is a single-cycle op with result 0, which sets Z=1 and N=0 and clears C/V.

## Structure
- Shared package `cpu_pkg` holds:
  - the ALUop enum (`ALU_MOV` … `ALU_MUL`)
  - the `mul_state_t` enum
  - a packed `ex_ctrl_t` struct for wbs/wme/mm/wm/am/ni
- The combinational ALU lives in one sub-module, `alu_flags`, parametrised by `WIDTH`. It outputs the result and next N/Z/C/V.
- The multiplier FSM, both slots and the flag register live in the top module.

## Test plan
- ADD: A=0x0001, B=0x0000, wbs=1 → after 2 edges `out_valid`=1, `ALUresult_out`=0x0001, `wbs_out`=1, N=0, Z=0.
- Store routing: am=1, A=0x000E, B=0x0DB2, wm=1 → `ALUresult_out`=0x000E, `memData_out`=0x0DB2, flags unchanged.
- SUB boundaries:
  - A=0x8000, B=0x0001 → result 0x7FFF, V=1, C=1, N=0.
  - A=B=0x1234 → result 0, Z=1.
- Back-pressure: stream 3 ADDs with `out_ready`=0 for 4 cycles → `out_valid` high and held stable, `in_ready` drops after 2 captures, all 3 results emerge in order with none lost.
- MUL (`EXEC_MUL_EN`): A=0x00FF, B=0x0003 → `busy`=1 for 17 cycles, `ALUresult_out`=0x02FD at edge 19. Flush during cycle 5 → `busy`=0 next edge, no output produced.
- Async reset mid-stream: `rst_n`=0 between edges → all outputs and flags read 0 immediately, `in_ready`=1 after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the pipelined CPU: ALU opcodes, multiplier FSM states and
// the control bits carried through the execute stage.
package cpu_pkg;

    typedef enum logic [2:0] {
        ALU_MOV = 3'b000,
        ALU_ADD = 3'b001,
        ALU_SUB = 3'b010,
        ALU_AND = 3'b011,
        ALU_OR  = 3'b100,
        ALU_XOR = 3'b101,
        ALU_SHL = 3'b110,
        ALU_MUL = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        MulIdle,
        MulRun,
        MulDone
    } mul_state_t;

    typedef struct packed {
        logic wbs;
        logic wme;
        logic mm;
        logic wm;
        logic am;
        logic ni;
    } ex_ctrl_t;

endpackage

// File: rtl/alu_flags.sv
// Combinational ALU for the execute stage: result plus next N/Z/C/V.
// MUL takes its result from the externally supplied product.
module alu_flags
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] mul_prod,
    output logic [WIDTH-1:0] result,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             v
);

    logic [WIDTH:0] sum;

    // Operation decode; C/V only meaningful for ADD/SUB, cleared otherwise
    always_comb begin
        sum    = '0;
        result = '0;
        c      = 1'b0;
        v      = 1'b0;
        case (op)
            ALU_MOV: result = b;
            ALU_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[WIDTH-1:0];
                c      = sum[WIDTH];
                v      = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                sum    = {1'b0, a} - {1'b0, b};
                result = sum[WIDTH-1:0];
                // Top bit of the extended difference is the borrow
                c      = !sum[WIDTH];
                v      = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SHL: result = a << b[SHAMT_W-1:0];
            ALU_MUL: result = mul_prod;
            default: result = '0;
        endcase
        n = result[WIDTH-1];
        z = (result == '0);
    end

endmodule

// File: rtl/execute_stage_pipe.sv
// Execute stage: decode->execute slot, ALU with sticky flags, address/store
// routing and execute->memory slot, joined by valid/ready handshakes.
// Define EXEC_MUL_EN to build the iterative shift-add multiplier; otherwise
// ALUop MUL is a single-cycle op returning 0 and busy is tied low.
module execute_stage_pipe
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             wbs_in,
    input  logic             wme_in,
    input  logic             mm_in,
    input  logic             wm_in,
    input  logic             am_in,
    input  logic             ni_in,
    input  logic [2:0]       ALUop_in,
    input  logic [WIDTH-1:0] srcA_in,
    input  logic [WIDTH-1:0] srcB_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             wbs_out,
    output logic             wme_out,
    output logic             mm_out,
    output logic             wm_out,
    output logic             ni_out,
    output logic [WIDTH-1:0] ALUresult_out,
    output logic [WIDTH-1:0] memData_out,
    output logic             flagN,
    output logic             flagZ,
    output logic             flagC,
    output logic             flagV,
    output logic             busy
);

    logic             e_valid_q, e_valid_d;
    ex_ctrl_t         e_ctrl_q;
    alu_op_t          e_op_q;
    logic [WIDTH-1:0] e_a_q, e_b_q;

    logic             m_valid_q;
    logic [4:0]       m_ctrl_q;  // {wbs, wme, mm, wm, ni}
    logic [WIDTH-1:0] m_result_q, m_data_q;
    logic [3:0]       flags_q;   // {N, Z, C, V}

    logic             advance, capture;
    logic [WIDTH-1:0] mul_prod, alu_result;
    logic             alu_n, alu_z, alu_c, alu_v;

    // Flush kills the execute slot, so it must not also advance into memory
    assign advance  = e_valid_q && !busy && (!m_valid_q || out_ready) && !flush;
    assign in_ready = !flush && !busy && (!e_valid_q || advance);
    assign capture  = in_valid && in_ready;

`ifdef EXEC_MUL_EN
    localparam logic [SHAMT_W:0] CntLast = (SHAMT_W + 1)'(WIDTH);
    localparam logic [SHAMT_W:0] CntOne  = (SHAMT_W + 1)'(1);

    mul_state_t       state_q, state_d;
    logic [SHAMT_W:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d;
    logic             start_mul;

    assign start_mul = capture && (alu_op_t'(ALUop_in) == ALU_MUL);
    assign busy      = (state_q == MulRun);
    assign mul_prod  = prod_q;

    // Multiplier next state: one shift-add per cycle, then a final count check
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        case (state_q)
            MulRun: begin
                if (cnt_q == CntLast) begin
                    state_d = MulDone;
                end else begin
                    if (mplier_q[0]) prod_d = prod_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CntOne;
                end
            end
            MulDone: if (advance) state_d = MulIdle;
            default: state_d = MulIdle;
        endcase
        // A new MUL may be captured in IDLE or in the DONE cycle that advances
        if (start_mul) begin
            state_d  = MulRun;
            cnt_d    = '0;
            mcand_d  = srcA_in;
            mplier_d = srcB_in;
            prod_d   = '0;
        end
        if (flush) state_d = MulIdle;
    end

    // Multiplier state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MulIdle;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end
`else
    assign busy     = 1'b0;
    assign mul_prod = '0;
`endif

    alu_flags #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_alu (
        .op       (e_op_q),
        .a        (e_a_q),
        .b        (e_b_q),
        .mul_prod (mul_prod),
        .result   (alu_result),
        .n        (alu_n),
        .z        (alu_z),
        .c        (alu_c),
        .v        (alu_v)
    );

    // Execute slot occupancy
    always_comb begin
        e_valid_d = e_valid_q;
        if (flush)        e_valid_d = 1'b0;
        else if (capture) e_valid_d = 1'b1;
        else if (advance) e_valid_d = 1'b0;
    end

    // Execute slot registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_valid_q <= 1'b0;
            e_ctrl_q  <= '0;
            e_op_q    <= ALU_MOV;
            e_a_q     <= '0;
            e_b_q     <= '0;
        end else begin
            e_valid_q <= e_valid_d;
            if (capture) begin
                e_ctrl_q <= '{wbs: wbs_in, wme: wme_in, mm: mm_in, wm: wm_in,
                              am: am_in, ni: ni_in};
                e_op_q   <= alu_op_t'(ALUop_in);
                e_a_q    <= srcA_in;
                e_b_q    <= srcB_in;
            end
        end
    end

    // Memory slot and sticky flags; address-mode instructions leave flags alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q  <= 1'b0;
            m_ctrl_q   <= '0;
            m_result_q <= '0;
            m_data_q   <= '0;
            flags_q    <= '0;
        end else if (advance) begin
            m_valid_q  <= 1'b1;
            m_ctrl_q   <= {e_ctrl_q.wbs, e_ctrl_q.wme, e_ctrl_q.mm, e_ctrl_q.wm, e_ctrl_q.ni};
            m_result_q <= e_ctrl_q.am ? e_a_q : alu_result;
            m_data_q   <= e_ctrl_q.am ? e_b_q : '0;
            if (!e_ctrl_q.am) flags_q <= {alu_n, alu_z, alu_c, alu_v};
        end else if (out_ready) begin
            m_valid_q  <= 1'b0;
        end
    end

    assign out_valid     = m_valid_q;
    assign wbs_out       = m_ctrl_q[4];
    assign wme_out       = m_ctrl_q[3];
    assign mm_out        = m_ctrl_q[2];
    assign wm_out        = m_ctrl_q[1];
    assign ni_out        = m_ctrl_q[0];
    assign ALUresult_out = m_result_q;
    assign memData_out   = m_data_q;
    assign flagN         = flags_q[3];
    assign flagZ         = flags_q[2];
    assign flagC         = flags_q[1];
    assign flagV         = flags_q[0];

endmodule
